ppdu_encoder_sequencer: RTL and testbench

//  Frame-level controller in front of the convolutional encoder. Takes one TX command
//  (RATE, LENGTH) and emits the PLCP SIGNAL word at RATE_6M. It then passes the scrambled

---
 rtl/ppdu_encoder_sequencer_if.sv | 35 +++
 rtl/ppdu_encoder_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_ppdu_encoder_sequencer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppdu_encoder_sequencer_if.sv
// Command port plus the upstream (s_axis) and encoder-facing (m_axis) streams of ppdu_encoder_sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface ppdu_encoder_sequencer_if #(
    parameter int WIDTH = 24,
    parameter int LEN_W = 12
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_rate;
    logic [LEN_W-1:0] cmd_length;
    logic [WIDTH-1:0] s_axis_tdata;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic [WIDTH-1:0] m_axis_tdata;
    logic [3:0]       m_axis_tuser;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             m_axis_tlast;

    modport slave (
        input  cmd_valid, cmd_rate, cmd_length,
        input  s_axis_tdata, s_axis_tvalid,
        input  m_axis_tready,
        output cmd_ready, s_axis_tready,
        output m_axis_tdata, m_axis_tuser, m_axis_tvalid, m_axis_tlast
    );

    modport master (
        output cmd_valid, cmd_rate, cmd_length,
        output s_axis_tdata, s_axis_tvalid,
        output m_axis_tready,
        input  cmd_ready, s_axis_tready,
        input  m_axis_tdata, m_axis_tuser, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/ppdu_encoder_sequencer.sv
// PPDU sequencer in front of the convolutional encoder: SIGNAL word at 6M, then DATA passthrough.
// Build macro SYM_PAD_EN adds zero pad words so the DATA field fills whole OFDM symbols.
module ppdu_encoder_sequencer #(
    parameter int WIDTH = 24,
    parameter int LEN_W = 12
) (
    input  logic                    aclk,
    input  logic                    areset,
    ppdu_encoder_sequencer_if.slave bus,
    output logic                    busy,
    output logic                    err_cmd
);
    // Rate codes are {R1,R2,R3,R4}, R1 in the MSB
    localparam logic [3:0] RATE_6M  = 4'b1101;
    localparam logic [3:0] RATE_9M  = 4'b1111;
    localparam logic [3:0] RATE_12M = 4'b0101;
    localparam logic [3:0] RATE_18M = 4'b0111;
    localparam logic [3:0] RATE_24M = 4'b1001;
    localparam logic [3:0] RATE_36M = 4'b1011;
    localparam logic [3:0] RATE_48M = 4'b0001;
    localparam logic [3:0] RATE_54M = 4'b0011;

    // Wide enough for 22 + 8*LENGTH at the largest LENGTH
    localparam int REM_W = LEN_W + 4;
    localparam logic [REM_W-1:0] WORD_BITS = REM_W'(5'd24);
    localparam logic [REM_W-1:0] HDR_BITS  = REM_W'(5'd22);

`ifdef SYM_PAD_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SIGNAL = 2'd1,
        ST_DATA   = 2'd2,
        ST_PAD    = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SIGNAL = 2'd1,
        ST_DATA   = 2'd2
    } state_t;
`endif

    function automatic logic even_parity(input logic [16:0] bits);
        return ^bits;
    endfunction

    function automatic logic [23:0] signal_word(input logic [3:0] rate, input logic [11:0] length);
        logic [16:0] low;
        low = {length, 1'b0, rate[0], rate[1], rate[2], rate[3]};
        return {6'd0, even_parity(low), low};
    endfunction

`ifdef SYM_PAD_EN
    function automatic logic [7:0] ndbps(input logic [3:0] rate);
        case (rate)
            RATE_6M:  ndbps = 8'd24;
            RATE_9M:  ndbps = 8'd36;
            RATE_12M: ndbps = 8'd48;
            RATE_18M: ndbps = 8'd72;
            RATE_24M: ndbps = 8'd96;
            RATE_36M: ndbps = 8'd144;
            RATE_48M: ndbps = 8'd192;
            RATE_54M: ndbps = 8'd216;
            default:  ndbps = 8'd24;
        endcase
    endfunction
`endif

    state_t             state_r;
    state_t             state_s;
    logic [3:0]         rate_r;
    logic [REM_W-1:0]   rem_bits_r;
    logic [WIDTH-1:0]   sig_word_r;
    logic               err_cmd_r;

    logic               cmd_accept_s;
    logic               cmd_ok_s;
    logic               last_data_s;
    logic               data_hs_s;
    logic               cmd_ready_s;
    logic               s_tready_s;
    logic [WIDTH-1:0]   m_tdata_s;
    logic [3:0]         m_tuser_s;
    logic               m_tvalid_s;
    logic               m_tlast_s;

`ifdef SYM_PAD_EN
    logic [7:0]         sym_acc_r;
    logic [7:0]         sym_next_s;
    logic [8:0]         sym_sum_s;
    logic [7:0]         ndbps_s;
    logic               pad_hs_s;

    // Symbol fill after emitting one more 24-bit word (24 <= NDBPS, so one wrap at most)
    always_comb begin
        ndbps_s   = ndbps(rate_r);
        sym_sum_s = {1'b0, sym_acc_r} + 9'd24;
        if (sym_sum_s >= {1'b0, ndbps_s}) begin
            sym_next_s = 8'(sym_sum_s - {1'b0, ndbps_s});
        end else begin
            sym_next_s = sym_sum_s[7:0];
        end
    end
`endif

    assign cmd_accept_s = (state_r == ST_IDLE) && bus.cmd_valid;
    assign cmd_ok_s     = bus.cmd_rate[0] && (bus.cmd_length != {LEN_W{1'b0}});
    assign last_data_s  = (rem_bits_r <= WORD_BITS);

    // Next-state and stream outputs for each frame phase
    always_comb begin
        state_s     = state_r;
        cmd_ready_s = 1'b0;
        s_tready_s  = 1'b0;
        m_tdata_s   = {WIDTH{1'b0}};
        m_tuser_s   = 4'd0;
        m_tvalid_s  = 1'b0;
        m_tlast_s   = 1'b0;
        data_hs_s   = 1'b0;
`ifdef SYM_PAD_EN
        pad_hs_s    = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                cmd_ready_s = 1'b1;
                if (bus.cmd_valid && cmd_ok_s) begin
                    state_s = ST_SIGNAL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SIGNAL: begin
                m_tdata_s  = sig_word_r;
                m_tuser_s  = RATE_6M;
                m_tvalid_s = 1'b1;
                m_tlast_s  = 1'b1;
                if (bus.m_axis_tready) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_SIGNAL;
                end
            end
            ST_DATA: begin
                m_tdata_s  = bus.s_axis_tdata;
                m_tvalid_s = bus.s_axis_tvalid;
                s_tready_s = bus.m_axis_tready;
                m_tuser_s  = rate_r;
                data_hs_s  = bus.s_axis_tvalid && bus.m_axis_tready;
`ifdef SYM_PAD_EN
                m_tlast_s  = last_data_s && (sym_next_s == 8'd0);
                if (data_hs_s && last_data_s) begin
                    if (sym_next_s == 8'd0) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_PAD;
                    end
                end else begin
                    state_s = ST_DATA;
                end
`else
                m_tlast_s  = last_data_s;
                if (data_hs_s && last_data_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DATA;
                end
`endif
            end
`ifdef SYM_PAD_EN
            ST_PAD: begin
                m_tuser_s  = rate_r;
                m_tvalid_s = 1'b1;
                m_tlast_s  = (sym_next_s == 8'd0);
                pad_hs_s   = bus.m_axis_tready;
                if (pad_hs_s && (sym_next_s == 8'd0)) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_PAD;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, command latch and per-word bit accounting
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r    <= ST_IDLE;
            rate_r     <= 4'd0;
            rem_bits_r <= {REM_W{1'b0}};
            sig_word_r <= {WIDTH{1'b0}};
            err_cmd_r  <= 1'b0;
`ifdef SYM_PAD_EN
            sym_acc_r  <= 8'd0;
`endif
        end else begin
            state_r   <= state_s;
            err_cmd_r <= cmd_accept_s && !cmd_ok_s;
            if (cmd_accept_s && cmd_ok_s) begin
                rate_r     <= bus.cmd_rate;
                rem_bits_r <= HDR_BITS + REM_W'({bus.cmd_length, 3'b000});
                sig_word_r <= WIDTH'(signal_word(bus.cmd_rate, bus.cmd_length));
`ifdef SYM_PAD_EN
                sym_acc_r  <= 8'd0;
`endif
            end else if (data_hs_s) begin
                if (!last_data_s) begin
                    rem_bits_r <= rem_bits_r - WORD_BITS;
                end else begin
                    rem_bits_r <= rem_bits_r;
                end
`ifdef SYM_PAD_EN
                sym_acc_r  <= sym_next_s;
            end else if (pad_hs_s) begin
                sym_acc_r  <= sym_next_s;
`endif
            end else begin
                rem_bits_r <= rem_bits_r;
            end
        end
    end

    // Reset forces every output low in the same cycle, so no word is sent or consumed
    assign bus.cmd_ready     = cmd_ready_s & ~areset;
    assign bus.s_axis_tready = s_tready_s & ~areset;
    assign bus.m_axis_tdata  = areset ? {WIDTH{1'b0}} : m_tdata_s;
    assign bus.m_axis_tuser  = areset ? 4'd0 : m_tuser_s;
    assign bus.m_axis_tvalid = m_tvalid_s & ~areset;
    assign bus.m_axis_tlast  = m_tlast_s & ~areset;
    assign busy              = (state_r != ST_IDLE) & ~areset;
    assign err_cmd           = err_cmd_r & ~areset;

endmodule

// File: tb/tb_ppdu_encoder_sequencer.sv
// Randomized bench for ppdu_encoder_sequencer against a frame-level reference model.
module tb_ppdu_encoder_sequencer;
    logic aclk = 1'b0;
    logic areset;
    logic busy;
    logic err_cmd;

    always #5 aclk = ~aclk;

    ppdu_encoder_sequencer_if #(.WIDTH(24), .LEN_W(12)) bus ();

    ppdu_encoder_sequencer #(.WIDTH(24), .LEN_W(12)) dut (
        .aclk    (aclk),
        .areset  (areset),
        .bus     (bus.slave),
        .busy    (busy),
        .err_cmd (err_cmd)
    );

    // 802.11a RATE field {R1..R4} and the matching data rate in Mbit/s
    logic [3:0] rate_code [8] = '{4'b1101, 4'b1111, 4'b0101, 4'b0111,
                                  4'b1001, 4'b1011, 4'b0001, 4'b0011};
    int         rate_mbps [8] = '{6, 9, 12, 18, 24, 36, 48, 54};
    localparam logic [3:0] R6  = 4'b1101;
    localparam logic [3:0] R36 = 4'b1011;
    localparam logic [3:0] R54 = 4'b0011;

    typedef struct {
        logic [23:0] data;
        logic [3:0]  user;
        logic        last;
        logic        from_src;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] src_q[$];
    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          rdy_mode = 0;
    bit          gap_en = 1'b0;
    bit          s_hs_seen = 1'b0;
    bit          stall_seen = 1'b0;
    logic [28:0] stall_word;
    int          data_seen = 0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] model_signal(input logic [3:0] rate, input logic [11:0] len);
        logic [23:0] w;
        int ones;
        w = 24'd0;
        ones = 0;
        for (int i = 0; i < 4; i++) w[i] = rate[3-i];
        for (int i = 0; i < 12; i++) w[5+i] = len[i];
        for (int i = 0; i < 17; i++) ones += int'(w[i]);
        w[17] = (ones % 2) == 1;
        return w;
    endfunction

    function automatic int ndbps_of(input logic [3:0] rate);
        for (int i = 0; i < 8; i++) if (rate_code[i] == rate) return 4 * rate_mbps[i];
        return 24;
    endfunction

    function automatic int lcm(input int a, input int b);
        int x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return a / x * b;
    endfunction

    task automatic sample();
        exp_t e;
        if (stall_seen) begin
            check_value("stall_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
            check_value("stall_hold", 64'({bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast}), 64'(stall_word));
        end
        stall_seen = bus.m_axis_tvalid && !bus.m_axis_tready;
        stall_word = {bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast};
        s_hs_seen  = bus.s_axis_tvalid && bus.s_axis_tready;
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            if (exp_q.size() == 0) begin
                check_value("unexpected_word", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check_value("tdata", 64'(bus.m_axis_tdata), 64'(e.data));
                check_value("tuser", 64'(bus.m_axis_tuser), 64'(e.user));
                check_value("tlast", 64'(bus.m_axis_tlast), 64'(e.last));
                check_value("s_tready", 64'(bus.s_axis_tready), 64'(e.from_src));
                if (e.from_src) data_seen++;
            end
        end
    endtask

    task automatic drive();
        if (s_hs_seen && src_q.size() > 0) src_q.delete(0);
        if (!(bus.s_axis_tvalid && !s_hs_seen)) begin
            if (src_q.size() > 0 && (!gap_en || $urandom_range(0, 1) == 1)) begin
                bus.s_axis_tvalid = 1'b1;
                bus.s_axis_tdata  = src_q[0];
            end else begin
                bus.s_axis_tvalid = 1'b0;
                bus.s_axis_tdata  = 24'($urandom);
            end
        end
        case (rdy_mode)
            0:       bus.m_axis_tready = 1'b1;
            1:       bus.m_axis_tready = ~bus.m_axis_tready;
            default: bus.m_axis_tready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic cycle();
        @(negedge aclk);
        sample();
        @(posedge aclk);
        #1;
        drive();
    endtask

    task automatic send_cmd(input logic [3:0] rate, input logic [11:0] len);
        int guard;
        guard = 0;
        while (!bus.cmd_ready && guard < 200) begin
            cycle();
            guard++;
        end
        if (guard >= 200) check_value("cmd_ready_timeout", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_rate   = rate;
        bus.cmd_length = len;
        cycle();
        bus.cmd_valid  = 1'b0;
    endtask

    task automatic reset_abort(input int left);
        areset = 1'b1;
        @(negedge aclk);
        check_value("rst_outputs_zero",
                    64'({bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tvalid, bus.m_axis_tlast,
                         bus.s_axis_tready, bus.cmd_ready, busy, err_cmd}), 64'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        check_value("post_rst_idle",
                    64'({bus.m_axis_tvalid, bus.m_axis_tlast, bus.s_axis_tready, busy, err_cmd, bus.cmd_ready}),
                    64'd1);
        check_value("src_unconsumed", 64'(src_q.size()), 64'(left));
        exp_q.delete();
        src_q.delete();
        bus.s_axis_tvalid = 1'b0;
        stall_seen = 1'b0;
        s_hs_seen  = 1'b0;
        @(posedge aclk);
        #1;
    endtask

    task automatic run_frame(input logic [3:0] rate, input logic [11:0] len, input int abort_at);
        int   nwords, npad, guard, blk, tot;
        logic [23:0] w;
        nwords = (22 + 8 * int'(len) + 23) / 24;
        npad   = 0;
        blk    = lcm(24, ndbps_of(rate));
        tot    = nwords * 24;
`ifdef SYM_PAD_EN
        npad   = ((tot + blk - 1) / blk * blk - tot) / 24;
`endif
        exp_q.push_back('{model_signal(rate, len), R6, 1'b1, 1'b0});
        for (int i = 0; i < nwords; i++) begin
            w = 24'($urandom);
            src_q.push_back(w);
            exp_q.push_back('{w, rate, (i == nwords - 1) && (npad == 0), 1'b1});
        end
        for (int i = 0; i < npad; i++) exp_q.push_back('{24'd0, rate, i == npad - 1, 1'b0});
        data_seen = 0;
        send_cmd(rate, len);
        guard = 0;
        while (exp_q.size() > 0 && guard < 20000) begin
            cycle();
            guard++;
            if (abort_at > 0 && data_seen == abort_at) begin
                reset_abort(nwords - abort_at);
                return;
            end
        end
        check_value("frame_drained", 64'(exp_q.size()), 64'd0);
        check_value("data_word_count", 64'(data_seen), 64'(nwords));
        @(negedge aclk);
        check_value("cmd_ready_after_frame", 64'(bus.cmd_ready), 64'd1);
        check_value("busy_after_frame", 64'(busy), 64'd0);
        sample();
        @(posedge aclk);
        #1;
        drive();
    endtask

    task automatic reject_cmd(input logic [3:0] rate, input logic [11:0] len);
        logic exp_err;
        exp_err = (rate[0] == 1'b0) || (len == 12'd0);
        bus.cmd_valid  = 1'b1;
        bus.cmd_rate   = rate;
        bus.cmd_length = len;
        @(negedge aclk);
        sample();
        @(posedge aclk);
        #1;
        bus.cmd_valid = 1'b0;
        drive();
        @(negedge aclk);
        check_value("err_cmd_pulse", 64'(err_cmd), 64'(exp_err));
        check_value("reject_no_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        check_value("reject_not_busy", 64'(busy), 64'd0);
        sample();
        @(posedge aclk);
        #1;
        drive();
        @(negedge aclk);
        check_value("err_cmd_one_cycle", 64'(err_cmd), 64'd0);
        check_value("reject_still_idle", 64'({busy, bus.cmd_ready}), 64'd1);
        sample();
        @(posedge aclk);
        #1;
        drive();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        areset            = 1'b1;
        bus.cmd_valid     = 1'b0;
        bus.cmd_rate      = 4'd0;
        bus.cmd_length    = 12'd0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = 24'd0;
        bus.m_axis_tready = 1'b1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check_value("reset_outputs_zero",
                    64'({bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tvalid, bus.m_axis_tlast,
                         bus.s_axis_tready, bus.cmd_ready, busy, err_cmd}), 64'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        check_value("cmd_ready_after_reset", 64'({bus.cmd_ready, busy}), 64'd2);
        @(posedge aclk);
        #1;

        rdy_mode = 0; gap_en = 1'b0;
        run_frame(R36, 12'd100, 0);
        run_frame(R6, 12'd1, 0);

        rdy_mode = 1; gap_en = 1'b1;
        run_frame(R36, 12'd100, 0);

        rdy_mode = 0; gap_en = 1'b0;
        reject_cmd(4'b0100, 12'd100);
        reject_cmd(R6, 12'd0);

        run_frame(R36, 12'd100, 10);
        run_frame(R6, 12'd1, 0);

        for (int n = 0; n < 16; n++) begin
            rdy_mode = $urandom_range(0, 2);
            gap_en   = 1'($urandom_range(0, 1));
            idx      = $urandom_range(0, 7);
            if ($urandom_range(0, 5) == 0) begin
                reject_cmd(4'($urandom) & 4'b1110, 12'($urandom_range(0, 200)));
            end else begin
                run_frame(rate_code[idx], 12'($urandom_range(1, 80)), 0);
            end
        end

        rdy_mode = 0; gap_en = 1'b0;
        run_frame(R54, 12'd4095, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
